uart_tx_serializer: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_serializer_if.sv | 18 +
 rtl/uart_tx_serializer_word_ring_buffer.sv | 73 +++++++
 rtl/uart_tx_serializer.sv | 83 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================
// uart_pkg : UART character constants shared by the tx and rx paths
// rev 1.0
// ============================================================
package uart_pkg;

  localparam int UART_WIDTH = 8;
  localparam int UART_PADS  = 2;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_SEND = 1'b1;

  function automatic int chars_for(input int width);
    return (width + UART_WIDTH - 1) / UART_WIDTH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================
// uart_tx_serializer_if : AXI-Stream data/valid/ready bundle
// rev 1.0
// ============================================================
interface uart_tx_serializer_if #(
  parameter int W = uart_pkg::UART_WIDTH
) ();

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer_word_ring_buffer.sv
`default_nettype none
// ============================================================
// word_ring_buffer : DEPTH-word ring with registered push ready
// rev 1.0
// ============================================================
module word_ring_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Storage rounded up to a power of two so the pointer width always indexes it exactly.
  logic [WIDTH-1:0] r_mem [2**PTR_W];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push = push_valid && r_ready;
  assign w_pop  = pop && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_next;
      // Ready looks only at the post-edge count: a pop while full frees space next cycle.
      r_ready <= (w_count_next < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign push_ready = r_ready;
  assign pop_data   = r_mem[r_rd_ptr];
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================
// uart_tx_serializer : buffers words and streams them LSB byte first
// rev 1.0
// ============================================================
module uart_tx_serializer import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         arstn,
  uart_tx_serializer_if.slave          s_axis,
  uart_tx_serializer_if.master         m_axis,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   words_pending
);

  localparam int BYTE_WIDTH = UART_WIDTH;
  localparam int CHARS      = chars_for(WIDTH);
  localparam int SHIFT_W    = CHARS * BYTE_WIDTH;
  localparam int IDX_W      = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic [0:0]         r_state;
  logic [SHIFT_W-1:0] r_shift;
  logic [IDX_W-1:0]   r_idx;
  logic               r_tvalid;
  logic [CNT_W-1:0]   w_count;
  logic [WIDTH-1:0]   w_pop_data;
  logic               w_m_hs;
  logic               w_last;
  logic               w_load;

  word_ring_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk        (clk),
    .arstn      (arstn),
    .push_data  (s_axis.tdata),
    .push_valid (s_axis.tvalid),
    .push_ready (s_axis.tready),
    .pop        (w_load),
    .pop_data   (w_pop_data),
    .count      (w_count)
  );

  assign w_m_hs = r_tvalid && m_axis.tready;
  assign w_last = (r_idx == IDX_W'(CHARS - 1));

  // Reloading on the last-byte handshake keeps tvalid high across word boundaries.
  assign w_load = (w_count != '0) &&
                  ((r_state == c_ST_IDLE) || ((r_state == c_ST_SEND) && w_m_hs && w_last));

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_state  <= c_ST_IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_tvalid <= 1'b0;
    end else if (w_load) begin
      r_shift  <= SHIFT_W'(w_pop_data);
      r_idx    <= '0;
      r_state  <= c_ST_SEND;
      r_tvalid <= 1'b1;
    end else if ((r_state == c_ST_SEND) && w_m_hs) begin
      if (w_last) begin
        r_state  <= c_ST_IDLE;
        r_tvalid <= 1'b0;
      end else begin
        r_shift <= r_shift >> BYTE_WIDTH;
        r_idx   <= r_idx + IDX_W'(1);
      end
    end
  end

  assign m_axis.tdata   = r_shift[BYTE_WIDTH-1:0];
  assign m_axis.tvalid  = r_tvalid;
  assign busy           = (r_state == c_ST_SEND) || (w_count != '0);
  assign words_pending  = w_count;

endmodule
`default_nettype wire
